gbox_tx_serializer: RTL and testbench

GBOX_TX_SERIALIZER -- requirements
Module: gbox_tx_serializer

---
 rtl/gbox_tx_serializer_pkg.sv | 11 +
 rtl/gbox_tx_serializer.sv | 120 ++++++++++++
 tb/tb_gbox_tx_serializer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/gbox_tx_serializer_pkg.sv
// Shared gearbox definitions: serializer state encoding and rate limits.
package gbox_tx_serializer_pkg;
  localparam int MIN_RATE  = 3;
  localparam int MAX_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } gbox_state_e;
endpackage

// File: rtl/gbox_tx_serializer.sv
// Gearbox TX serializer: loads a parallel word on the word_load_en strobe and
// shifts it out LSB first at rate_q bits per word, with sticky framing errors.
module gbox_tx_serializer
  import gbox_tx_serializer_pkg::*;
#(
  parameter int MAX_W = MAX_W_DEF
) (
  input  logic             fast_clk,
  input  logic             rst,
  input  logic [3:0]       rate_sel,
  input  logic             word_load_en,
  input  logic [MAX_W-1:0] tx_data,
  input  logic             tx_oe_in,
  input  logic             clear_err,
  output logic             tx_dout,
  output logic             tx_oe,
  output logic             word_taken,
  output logic             underrun_err,
  output logic             misalign_err,
  output logic             rate_err
);

  gbox_state_e      state_q, state_d;
  logic [MAX_W-1:0] sr_q, sr_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]       rate_q, rate_d;
  logic             oe_q, oe_d;
  logic             dout_q, dout_d;
  logic             oe_out_q, oe_out_d;
  logic             wt_q, wt_d;
  logic             und_q, und_d, und_set;
  logic             mis_q, mis_d, mis_set;
  logic             rerr_q, rerr_d, rerr_set;
  logic             rate_ok, last_bit;

  assign rate_ok  = (int'(rate_sel) >= MIN_RATE) && (int'(rate_sel) <= MAX_W);
  assign last_bit = (bit_cnt_q == rate_q - 4'd1);

  // The shift register holds the word with the bit currently on tx_dout at
  // sr_q[0], so the next bit is always sr_q[1]; outputs default to 0 so that
  // IDLE, HALT and any rejected strobe drive a quiet line.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    rate_d    = rate_q;
    oe_d      = oe_q;
    dout_d    = 1'b0;
    oe_out_d  = 1'b0;
    wt_d      = 1'b0;
    und_set   = 1'b0;
    mis_set   = 1'b0;
    rerr_set  = 1'b0;

    if (word_load_en && rate_ok) begin
      sr_d      = tx_data;
      dout_d    = tx_data[0];
      oe_d      = tx_oe_in;
      oe_out_d  = tx_oe_in;
      rate_d    = rate_sel;
      bit_cnt_d = 4'd0;
      wt_d      = 1'b1;
      state_d   = RUN;
      mis_set   = (state_q == RUN) && !last_bit;
    end else if (word_load_en) begin
      rerr_set = 1'b1;
      state_d  = HALT;
    end else if (state_q == RUN) begin
      if (last_bit) begin
        und_set = 1'b1;
        state_d = HALT;
      end else begin
        sr_d      = sr_q >> 1;
        dout_d    = sr_q[1];
        oe_out_d  = oe_q;
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end

    und_d  = (und_q  & ~clear_err) | und_set;
    mis_d  = (mis_q  & ~clear_err) | mis_set;
    rerr_d = (rerr_q & ~clear_err) | rerr_set;
  end

  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_cnt_q <= 4'd0;
      rate_q    <= 4'(MAX_W);
      oe_q      <= 1'b0;
      dout_q    <= 1'b0;
      oe_out_q  <= 1'b0;
      wt_q      <= 1'b0;
      und_q     <= 1'b0;
      mis_q     <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      rate_q    <= rate_d;
      oe_q      <= oe_d;
      dout_q    <= dout_d;
      oe_out_q  <= oe_out_d;
      wt_q      <= wt_d;
      und_q     <= und_d;
      mis_q     <= mis_d;
      rerr_q    <= rerr_d;
    end
  end

  assign tx_dout      = dout_q;
  assign tx_oe        = oe_out_q;
  assign word_taken   = wt_q;
  assign underrun_err = und_q;
  assign misalign_err = mis_q;
  assign rate_err     = rerr_q;

endmodule

// File: tb/tb_gbox_tx_serializer.sv
// Scoreboard bench for gbox_tx_serializer: expected serial bits are queued when
// a word is driven and popped one per clock as the serializer emits them.
module tb_gbox_tx_serializer;
  import gbox_tx_serializer_pkg::*;

  localparam int MAX_W = 10;

  logic             fast_clk = 1'b0;
  logic             rst;
  logic [3:0]       rate_sel;
  logic             word_load_en;
  logic [MAX_W-1:0] tx_data;
  logic             tx_oe_in;
  logic             clear_err;
  logic             tx_dout, tx_oe, word_taken;
  logic             underrun_err, misalign_err, rate_err;

  always #5 fast_clk = ~fast_clk;

  gbox_tx_serializer #(.MAX_W(MAX_W)) dut (
    .fast_clk    (fast_clk),
    .rst         (rst),
    .rate_sel    (rate_sel),
    .word_load_en(word_load_en),
    .tx_data     (tx_data),
    .tx_oe_in    (tx_oe_in),
    .clear_err   (clear_err),
    .tx_dout     (tx_dout),
    .tx_oe       (tx_oe),
    .word_taken  (word_taken),
    .underrun_err(underrun_err),
    .misalign_err(misalign_err),
    .rate_err    (rate_err)
  );

  typedef struct {
    logic dout;
    logic oe;
    logic wt;
  } exp_t;

  exp_t sbq[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [MAX_W-1:0] d, input int n, input logic oe);
    for (int k = 0; k < n; k++) sbq.push_back('{dout: d[k], oe: oe, wt: (k == 0)});
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) sbq.push_back('{dout: 1'b0, oe: 1'b0, wt: 1'b0});
  endtask

  // One clock: strobes are single-cycle, outputs compared 1 time unit after the edge.
  task automatic tick();
    exp_t e;
    @(posedge fast_clk);
    #1;
    word_load_en = 1'b0;
    clear_err    = 1'b0;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("tx_dout", 32'(tx_dout), 32'(e.dout));
      chk("tx_oe", 32'(tx_oe), 32'(e.oe));
      chk("word_taken", 32'(word_taken), 32'(e.wt));
    end
  endtask

  // n is how many bits of this word are expected to reach the line.
  task automatic load(input logic [3:0] r, input logic [MAX_W-1:0] d, input logic oe, input int n);
    rate_sel     = r;
    tx_data      = d;
    tx_oe_in     = oe;
    word_load_en = 1'b1;
    push_word(d, n, oe);
  endtask

  task automatic flags(input string tag, input logic u, input logic m, input logic r);
    chk({tag, "_underrun"}, 32'(underrun_err), 32'(u));
    chk({tag, "_misalign"}, 32'(misalign_err), 32'(m));
    chk({tag, "_rate"}, 32'(rate_err), 32'(r));
  endtask

  task automatic clear_flags();
    clear_err = 1'b1;
    push_idle(1);
    tick();
    flags("clear", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst          = 1'b1;
    rate_sel     = 4'd4;
    word_load_en = 1'b0;
    tx_data      = '0;
    tx_oe_in     = 1'b0;
    clear_err    = 1'b0;
    repeat (2) @(posedge fast_clk);
    #1;
    chk("rst_dout", 32'(tx_dout), 32'd0);
    chk("rst_oe", 32'(tx_oe), 32'd0);
    chk("rst_wt", 32'(word_taken), 32'd0);
    flags("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_rate_q", 32'(dut.rate_q), 32'(MAX_W));
    rst = 1'b0;
    push_idle(3);
    repeat (3) tick();
    chk("idle_state", 32'(dut.state_q), 32'(IDLE));

    // Rate 4, back-to-back 4'hA then 4'h5, then underrun.
    load(4'd4, 10'hA, 1'b1, 4);
    repeat (4) tick();
    load(4'd4, 10'h5, 1'b1, 4);
    repeat (4) tick();
    flags("b2b", 1'b0, 1'b0, 1'b0);
    push_idle(1);
    tick();
    flags("b2b_end", 1'b1, 1'b0, 1'b0);
    chk("b2b_halt", 32'(dut.state_q), 32'(HALT));
    clear_flags();

    // Rate 10 full word with oe, then HALT with zeros.
    load(4'd10, 10'h3C1, 1'b1, 10);
    repeat (10) tick();
    push_idle(2);
    repeat (2) tick();
    flags("r10", 1'b1, 1'b0, 1'b0);
    clear_flags();

    // Rate 8, early reload at bit_cnt=5 truncates and resyncs.
    load(4'd8, 10'h0B5, 1'b1, 6);
    repeat (6) tick();
    load(4'd8, 10'h0CA, 1'b0, 8);
    tick();
    chk("misalign_set", 32'(misalign_err), 32'd1);
    repeat (7) tick();
    push_idle(1);
    tick();
    flags("mis_end", 1'b1, 1'b1, 1'b0);
    clear_flags();

    // Illegal rate: flag, HALT, no word_taken; then clear plus legal load together.
    rate_sel     = 4'd2;
    word_load_en = 1'b1;
    push_idle(1);
    tick();
    flags("rerr", 1'b0, 1'b0, 1'b1);
    chk("rerr_halt", 32'(dut.state_q), 32'(HALT));
    clear_err = 1'b1;
    load(4'd5, 10'h13, 1'b1, 5);
    tick();
    chk("rerr_cleared", 32'(rate_err), 32'd0);
    repeat (4) tick();
    push_idle(1);
    tick();
    // Set wins over clear in the same cycle (rate above MAX_W).
    clear_err    = 1'b1;
    rate_sel     = 4'd11;
    word_load_en = 1'b1;
    push_idle(1);
    tick();
    flags("setwins", 1'b0, 1'b0, 1'b1);
    clear_flags();

    // rate_sel change mid-word does not affect the word in flight.
    load(4'd6, 10'h2D, 1'b1, 6);
    tick();
    rate_sel = 4'd3;
    repeat (5) tick();
    load(4'd3, 10'h3FE, 1'b1, 3);
    repeat (3) tick();
    push_idle(3);
    repeat (3) tick();
    flags("rchg", 1'b1, 1'b0, 1'b0);
    clear_flags();

    // Reset at bit 3 of a 10-bit word aborts immediately.
    load(4'd10, 10'h3FF, 1'b1, 4);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("arst_dout", 32'(tx_dout), 32'd0);
    chk("arst_oe", 32'(tx_oe), 32'd0);
    push_idle(1);
    tick();
    rst = 1'b0;
    push_idle(3);
    repeat (3) tick();
    chk("arst_idle", 32'(dut.state_q), 32'(IDLE));
    flags("arst", 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
